dac_sample_pacer: RTL and testbench
===================================

# dac_sample_pacer

Upstream feeder for the 10-bit DAC. Accepts 10-bit samples from the RISC-V core over a valid/ready handshake and buffers them in a small FIFO. Presents them on the DAC `D`/`EN` inputs at a fixed programmable update rate, so the analog output steps at even intervals regardless of core timing jitter. Flags underrun when the core falls behind.

## Interface
Parameters:
- `DEPTH`, 8: FIFO entries; power of two, ≥ 4.
- `DIV_W`, 16: width of the rate divider.

Ports:
- `CLK`  in  1  system clock; all state updates on its rising edge.
- `RST_N`  in  1  asynchronous, active-low reset.
- `ENABLE`  in  1  run request from the core control register.
- `DIV`  in  DIV_W  update period minus 1, in `CLK` cycles.
- `IN_DATA`  in  10  sample from the core.
- `IN_VALID`  in  1  `IN_DATA` is valid.
- `IN_READY`  out  1  FIFO can accept; equals `!full` (registered state, no combinational path from `IN_VALID`).
- `D`  out  10  DAC code; drives DAC `D`.
- `EN`  out  1  DAC enable; drives DAC `EN`.
- `LEVEL`  out  $clog2(DEPTH)+1  current FIFO occupancy.
- `UNDERRUN`  out  1  sticky: an update tick found the FIFO empty.

## Operation
- Reset values: `D`=0, `EN`=0, `UNDERRUN`=0, `LEVEL`=0, `IN_READY`=1. FIFO is empty, the divider count is 0, and the FSM is in OFF.
- Push: when `IN_VALID && IN_READY`, write `IN_DATA` and increment the level. Pushes are accepted in every FSM state, including OFF.
- FSM states:
  - **OFF**: `EN`=0, `D`=0. Enter **PRIME** when `ENABLE`=1.
  - **PRIME**: `EN`=0. Enter **RUN** when level ≥ DEPTH/2. Return to OFF when `ENABLE`=0.
  - **RUN**: `EN`=1.
    - Each tick pops one sample into `D`.
    - If a tick finds the FIFO empty, `D` holds its value, `UNDERRUN` is set, and the FSM stays in RUN.
    - When `ENABLE`=0, go to OFF.
- Entering OFF from PRIME or RUN:
  - FIFO is flushed (level becomes 0).
  - `D` and `EN` are cleared.
  - `UNDERRUN` is cleared.
- `ENABLE` dropping has priority over a coincident tick.
- Divider:
  - Loaded with `DIV` on the PRIME→RUN transition and at every tick.
  - Decrements each cycle in RUN; a tick occurs when it reaches 0.
  - `DIV` is sampled only at load, so changes take effect from the next period.
- Simultaneous push and pop:
  - At level 0: the pop sees empty and raises underrun; the push is stored. There is no bypass.
  - At full: no push can occur because `IN_READY`=0.
  - At any other level: the level is unchanged.
- Pointers wrap modulo DEPTH. Level saturates at neither bound; the handshake rules make overflow and underflow impossible.

## Timing
- PRIME→RUN edge: `EN` rises and `D` loads the head sample on the same edge. The first update has zero extra latency.
- Later updates occur every `DIV`+1 cycles. `DIV`=0 gives one sample per cycle.
- Push to earliest pop: 1 cycle, since a sample written at edge N is visible at edge N+1.
- The RUN→OFF transition takes one edge after `ENABLE` falls. `EN`=0 and `D`=0 from that edge.
- `UNDERRUN` is set on the tick edge and remains set until OFF is entered or reset occurs.
- Asserting `RST_N` low in any state forces all reset values immediately.

## Structure
- Shared package holds:
  - `DAC_W`=10.
  - FSM state enum {OFF, PRIME, RUN}.
  - `DAC_FULL_SCALE`=10'h3FF.
- One sub-module, `dac_sample_fifo`: synchronous FIFO with DEPTH×DAC_W storage, push/pop, full/empty and level. The top level contains the FSM, divider and output registers.

## Test plan
- Reset and prime: reset, push 3 samples, set `ENABLE`=1 → `EN` stays 0. Push a 4th sample (level 4 = DEPTH/2) → `EN`=1 and `D`=first sample on the next edge.
- Pacing: `DIV`=4, push 0x000, 0x155, 0x2AA, 0x3FF → `D` steps exactly every 5 cycles in order; `UNDERRUN`=0.
- Underrun: `DIV`=2, 4 samples, no further pushes → 5th tick keeps `D`=last sample (0x3FF) and sets `UNDERRUN`=1, which stays set.
- Backpressure: hold `IN_VALID`=1 with `ENABLE`=0 → after 8 pushes `IN_READY`=0 and `LEVEL`=8. Pulse `ENABLE` and run `DIV`=0 → each pop reasserts `IN_READY` and the level never exceeds 8.
- Disable mid-run: drop `ENABLE` on a tick cycle with level 3 → next edge gives `EN`=0, `D`=0, `LEVEL`=0, `UNDERRUN`=0, and no pop is applied.
- Async reset mid-RUN: pull `RST_N` low between edges → outputs reach reset values immediately without a clock edge.

Source files
------------

// File: rtl/dac_sample_pacer_pkg.sv
// Shared definitions for the DAC sample pacer: sample width, full-scale code and FSM states.
package dac_sample_pacer_pkg;

   localparam int DAC_W = 10;
   localparam logic [DAC_W-1:0] DAC_FULL_SCALE = 10'h3FF;

   typedef enum logic [1:0] {
      OFF,
      PRIME,
      RUN
   } pacer_state_e;

endpackage

// File: rtl/dac_sample_fifo.sv
// Synchronous FIFO holding DAC samples between the core handshake and the pacing logic.
module dac_sample_fifo
   import dac_sample_pacer_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   i_flush,
   input  logic                   i_push,
   input  logic [DAC_W-1:0]       i_data,
   input  logic                   i_pop,
   output logic [DAC_W-1:0]       o_head,
   output logic                   o_full,
   output logic                   o_empty,
   output logic [$clog2(DEPTH):0] o_level
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = PTR_W + 1;

   logic [DAC_W-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wrPtr;
   logic [PTR_W-1:0] r_rdPtr;
   logic [LVL_W-1:0] r_level;

   // Storage is not reset; the pointers and level alone decide which entries are valid.
   always_ff @(posedge clk) begin
      if (i_push && !i_flush) begin
         r_mem[r_wrPtr] <= i_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_level <= '0;
      end else if (i_flush) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_level <= '0;
      end else begin
         if (i_push) begin
            r_wrPtr <= r_wrPtr + 1'b1;
         end
         if (i_pop) begin
            r_rdPtr <= r_rdPtr + 1'b1;
         end
         case ({i_push, i_pop})
            2'b10:   r_level <= r_level + 1'b1;
            2'b01:   r_level <= r_level - 1'b1;
            default: r_level <= r_level;
         endcase
      end
   end

   assign o_head  = r_mem[r_rdPtr];
   assign o_full  = (r_level == LVL_W'(DEPTH));
   assign o_empty = (r_level == '0);
   assign o_level = r_level;

endmodule

// File: rtl/dac_sample_pacer.sv
// Paces buffered core samples onto the DAC D/EN inputs at a fixed programmable rate.
module dac_sample_pacer
   import dac_sample_pacer_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int DIV_W = 16
) (
   input  logic                   CLK,
   input  logic                   RST_N,
   input  logic                   ENABLE,
   input  logic [DIV_W-1:0]       DIV,
   input  logic [DAC_W-1:0]       IN_DATA,
   input  logic                   IN_VALID,
   output logic                   IN_READY,
   output logic [DAC_W-1:0]       D,
   output logic                   EN,
   output logic [$clog2(DEPTH):0] LEVEL,
   output logic                   UNDERRUN
);
   localparam int LVL_W = $clog2(DEPTH) + 1;

   pacer_state_e     r_state;
   pacer_state_e     w_nextState;
   logic [DIV_W-1:0] r_divCnt;
   logic [DAC_W-1:0] r_d;
   logic             r_en;
   logic             r_underrun;

   logic             w_push;
   logic             w_pop;
   logic             w_flush;
   logic             w_tick;
   logic             w_startRun;
   logic             w_full;
   logic             w_empty;
   logic [DAC_W-1:0] w_head;
   logic [LVL_W-1:0] w_level;

   assign w_push = IN_VALID && !w_full;

   dac_sample_fifo #(
      .DEPTH(DEPTH)
   ) u_fifo (
      .clk    (CLK),
      .rst_n  (RST_N),
      .i_flush(w_flush),
      .i_push (w_push),
      .i_data (IN_DATA),
      .i_pop  (w_pop),
      .o_head (w_head),
      .o_full (w_full),
      .o_empty(w_empty),
      .o_level(w_level)
   );

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_state <= OFF;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Dropping ENABLE is checked first so it always beats a tick on the same cycle.
   always_comb begin
      w_nextState = r_state;
      w_pop       = 1'b0;
      w_flush     = 1'b0;
      w_tick      = 1'b0;
      w_startRun  = 1'b0;
      case (r_state)
         OFF: begin
            if (ENABLE) begin
               w_nextState = PRIME;
            end
         end
         PRIME: begin
            if (!ENABLE) begin
               w_nextState = OFF;
               w_flush     = 1'b1;
            end else if (w_level >= LVL_W'(DEPTH / 2)) begin
               w_nextState = RUN;
               w_startRun  = 1'b1;
               w_pop       = 1'b1;
            end
         end
         RUN: begin
            if (!ENABLE) begin
               w_nextState = OFF;
               w_flush     = 1'b1;
            end else if (r_divCnt == '0) begin
               w_tick = 1'b1;
               w_pop  = !w_empty;
            end
         end
         default: begin
            w_nextState = OFF;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_divCnt <= '0;
      end else if (w_flush) begin
         r_divCnt <= '0;
      end else if (w_startRun || w_tick) begin
         r_divCnt <= DIV;
      end else if (r_state == RUN) begin
         r_divCnt <= r_divCnt - 1'b1;
      end
   end

   // An empty tick leaves D on the last sample so the analog output holds steady.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_d        <= '0;
         r_en       <= 1'b0;
         r_underrun <= 1'b0;
      end else if (w_flush) begin
         r_d        <= '0;
         r_en       <= 1'b0;
         r_underrun <= 1'b0;
      end else if (w_startRun) begin
         r_d  <= w_head;
         r_en <= 1'b1;
      end else if (w_tick) begin
         if (w_empty) begin
            r_underrun <= 1'b1;
         end else begin
            r_d <= w_head;
         end
      end
   end

   assign IN_READY = !w_full;
   assign D        = r_d;
   assign EN       = r_en;
   assign LEVEL    = w_level;
   assign UNDERRUN = r_underrun;

endmodule

// File: tb/tb_dac_sample_pacer.sv
// Directed bench for dac_sample_pacer: vector table for prime/pacing, hand sequences for corner cases.
module tb_dac_sample_pacer;
   import dac_sample_pacer_pkg::*;

   localparam int DEPTH = 8;
   localparam int DIV_W = 16;

   logic             clk = 1'b0;
   logic             rstN;
   logic             enable;
   logic [DIV_W-1:0] divVal;
   logic [9:0]       inData;
   logic             inValid;
   logic             inReady;
   logic [9:0]       dOut;
   logic             enOut;
   logic [3:0]       level;
   logic             underrun;

   int checksTotal  = 0;
   int checksPassed = 0;

   typedef struct {
      logic        en;
      logic [15:0] dv;
      logic [9:0]  data;
      logic        valid;
      logic [9:0]  expD;
      logic        expEn;
      logic [3:0]  expLevel;
      logic        expUnd;
      logic        expRdy;
   } vec_t;

   vec_t vecs[$];
   logic [9:0] samp [4];

   always #5 clk = ~clk;

   dac_sample_pacer #(
      .DEPTH(DEPTH),
      .DIV_W(DIV_W)
   ) dut (
      .CLK     (clk),
      .RST_N   (rstN),
      .ENABLE  (enable),
      .DIV     (divVal),
      .IN_DATA (inData),
      .IN_VALID(inValid),
      .IN_READY(inReady),
      .D       (dOut),
      .EN      (enOut),
      .LEVEL   (level),
      .UNDERRUN(underrun)
   );

   task automatic addRow(input logic en, input logic [15:0] dv, input logic [9:0] data,
                         input logic valid, input logic [9:0] eD, input logic eEn,
                         input logic [3:0] eLvl, input logic eUnd, input logic eRdy);
      vec_t v;
      v.en = en; v.dv = dv; v.data = data; v.valid = valid;
      v.expD = eD; v.expEn = eEn; v.expLevel = eLvl; v.expUnd = eUnd; v.expRdy = eRdy;
      vecs.push_back(v);
   endtask

   task automatic applyStimulus(input logic en, input logic [15:0] dv,
                                input logic [9:0] data, input logic valid);
      enable  = en;
      divVal  = dv;
      inData  = data;
      inValid = valid;
   endtask

   task automatic checkOutput(input string name, input int actual, input int expected);
      checksTotal++;
      if (actual == expected) begin
         checksPassed++;
      end else begin
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic checkAll(input string tag, input logic [9:0] eD, input logic eEn,
                           input logic [3:0] eLvl, input logic eUnd, input logic eRdy);
      checkOutput({tag, " D"}, int'(dOut), int'(eD));
      checkOutput({tag, " EN"}, int'(enOut), int'(eEn));
      checkOutput({tag, " LEVEL"}, int'(level), int'(eLvl));
      checkOutput({tag, " UNDERRUN"}, int'(underrun), int'(eUnd));
      checkOutput({tag, " IN_READY"}, int'(inReady), int'(eRdy));
   endtask

   task automatic stepCycle();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic resetDut();
      rstN = 1'b0;
      applyStimulus(1'b0, 16'd0, 10'd0, 1'b0);
      @(negedge clk);
      rstN = 1'b1;
   endtask

   initial begin
      samp = '{10'h011, 10'h022, 10'h033, DAC_FULL_SCALE};

      // Prime then pace at DIV=4: three pushes with ENABLE keep EN low, the fourth starts RUN.
      addRow(1'b0, 16'd4, 10'h000, 1'b1, 10'h000, 1'b0, 4'd1, 1'b0, 1'b1);
      addRow(1'b0, 16'd4, 10'h155, 1'b1, 10'h000, 1'b0, 4'd2, 1'b0, 1'b1);
      addRow(1'b1, 16'd4, 10'h2AA, 1'b1, 10'h000, 1'b0, 4'd3, 1'b0, 1'b1);
      addRow(1'b1, 16'd4, 10'h000, 1'b0, 10'h000, 1'b0, 4'd3, 1'b0, 1'b1);
      addRow(1'b1, 16'd4, 10'h3FF, 1'b1, 10'h000, 1'b0, 4'd4, 1'b0, 1'b1);
      addRow(1'b1, 16'd4, 10'h000, 1'b0, 10'h000, 1'b1, 4'd3, 1'b0, 1'b1);
      for (int i = 0; i < 4; i++) addRow(1'b1, 16'd4, 10'h0, 1'b0, 10'h000, 1'b1, 4'd3, 1'b0, 1'b1);
      addRow(1'b1, 16'd4, 10'h0, 1'b0, 10'h155, 1'b1, 4'd2, 1'b0, 1'b1);
      for (int i = 0; i < 4; i++) addRow(1'b1, 16'd4, 10'h0, 1'b0, 10'h155, 1'b1, 4'd2, 1'b0, 1'b1);
      addRow(1'b1, 16'd4, 10'h0, 1'b0, 10'h2AA, 1'b1, 4'd1, 1'b0, 1'b1);
      for (int i = 0; i < 4; i++) addRow(1'b1, 16'd4, 10'h0, 1'b0, 10'h2AA, 1'b1, 4'd1, 1'b0, 1'b1);
      addRow(1'b1, 16'd4, 10'h0, 1'b0, 10'h3FF, 1'b1, 4'd0, 1'b0, 1'b1);
      for (int i = 0; i < 4; i++) addRow(1'b1, 16'd4, 10'h0, 1'b0, 10'h3FF, 1'b1, 4'd0, 1'b0, 1'b1);
      addRow(1'b1, 16'd4, 10'h0, 1'b0, 10'h3FF, 1'b1, 4'd0, 1'b1, 1'b1);
      addRow(1'b1, 16'd4, 10'h0, 1'b0, 10'h3FF, 1'b1, 4'd0, 1'b1, 1'b1);
      addRow(1'b0, 16'd4, 10'h0, 1'b0, 10'h000, 1'b0, 4'd0, 1'b0, 1'b1);

      rstN = 1'b0;
      applyStimulus(1'b0, 16'd0, 10'd0, 1'b0);
      @(negedge clk);
      checkAll("reset", 10'h000, 1'b0, 4'd0, 1'b0, 1'b1);
      rstN = 1'b1;

      foreach (vecs[i]) begin
         applyStimulus(vecs[i].en, vecs[i].dv, vecs[i].data, vecs[i].valid);
         stepCycle();
         checkAll($sformatf("vec%0d", i), vecs[i].expD, vecs[i].expEn,
                  vecs[i].expLevel, vecs[i].expUnd, vecs[i].expRdy);
      end

      // Underrun at DIV=2: the fifth tick holds full scale and sets the sticky flag.
      resetDut();
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b0, 16'd2, samp[i], 1'b1);
         stepCycle();
      end
      applyStimulus(1'b1, 16'd2, 10'd0, 1'b0);
      stepCycle();
      checkAll("underrun prime", 10'h000, 1'b0, 4'd4, 1'b0, 1'b1);
      for (int k = 0; k < 16; k++) begin
         int idx;
         idx = (k / 3 > 3) ? 3 : k / 3;
         stepCycle();
         checkAll($sformatf("underrun k%0d", k), samp[idx], 1'b1,
                  4'(3 - idx), (k >= 12), 1'b1);
      end

      // Async reset between edges while in RUN with UNDERRUN set.
      #2 rstN = 1'b0;
      #1 checkAll("async reset", 10'h000, 1'b0, 4'd0, 1'b0, 1'b1);
      @(negedge clk);
      rstN = 1'b1;

      // Backpressure: fill while OFF, then drain at DIV=0 with IN_VALID held high.
      resetDut();
      for (int i = 1; i <= 9; i++) begin
         applyStimulus(1'b0, 16'd0, 10'(i), 1'b1);
         stepCycle();
      end
      checkAll("fill", 10'h000, 1'b0, 4'd8, 1'b0, 1'b0);
      applyStimulus(1'b1, 16'd0, 10'd9, 1'b1);
      stepCycle();
      checkAll("full prime", 10'h000, 1'b0, 4'd8, 1'b0, 1'b0);
      stepCycle();
      checkAll("full first pop", 10'h001, 1'b1, 4'd7, 1'b0, 1'b1);
      for (int k = 0; k < 10; k++) begin
         stepCycle();
         checkAll($sformatf("drain k%0d", k), 10'(2 + k), 1'b1, 4'd7, 1'b0, 1'b1);
         applyStimulus(1'b1, 16'd0, 10'(10 + k), 1'b1);
      end

      // Disable on a tick cycle with three samples left: flush wins over the pop.
      resetDut();
      for (int i = 1; i <= 5; i++) begin
         applyStimulus(1'b0, 16'd2, 10'(16'h100 + i), 1'b1);
         stepCycle();
      end
      applyStimulus(1'b1, 16'd2, 10'd0, 1'b0);
      for (int i = 0; i < 7; i++) stepCycle();
      checkAll("pre-disable", 10'h102, 1'b1, 4'd3, 1'b0, 1'b1);
      applyStimulus(1'b0, 16'd2, 10'd0, 1'b0);
      stepCycle();
      checkAll("disable", 10'h000, 1'b0, 4'd0, 1'b0, 1'b1);
      stepCycle();
      checkAll("stay off", 10'h000, 1'b0, 4'd0, 1'b0, 1'b1);

      $display("%0d/%0d checks passed", checksPassed, checksTotal);
      $finish;
   end

endmodule
